// File: rtl/rast_mem_pkg.sv
// Shared types and constants for the rasteriser SDRAM port arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rast_mem_pkg;

  localparam int ADDR_W = 26;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_VFETCH = 2'd0;
  localparam req_id_t REQ_ZFETCH = 2'd1;
  localparam req_id_t REQ_ZWRITE = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Round-robin successor over the three requesters.
  function automatic req_id_t next_id(input req_id_t id);
    return (id == REQ_ZWRITE) ? REQ_VFETCH : req_id_t'(id + 2'd1);
  endfunction

  // First eligible requester at or after ptr, wrapping modulo 3.
  // Scans from the farthest candidate back so the nearest one wins.
  function automatic req_id_t rr_pick(input logic [2:0] elig, input req_id_t ptr);
    req_id_t pick;
    req_id_t cand;
    pick = ptr;
    for (int k = 2; k >= 0; k--) begin
      cand = req_id_t'((int'(ptr) + k) % 3);
      if (elig[cand]) pick = cand;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for reads outstanding at the SDRAM port.
// Latency: push visible at head the cycle after; pop is combinational on the head.
// Backpressure: none; a push while full is dropped unless a pop frees the slot in the same cycle.
module arb_id_fifo
  import rast_mem_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  req_id_t                push_data,
  output req_id_t                data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  req_id_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_CNT);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign data      = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM port among vertex fetch, depth fetch and z-test write.
// Latency: request seen in IDLE is granted next cycle; accepted that cycle if the port is not stalled.
// Backpressure: master_waitrequest stalls the granted requester; reads are held off when MAX_PENDING are in flight.
module mem_port_arbiter
  import rast_mem_pkg::*;
#(
  parameter int MAX_PENDING = 8,
  parameter int NREQ        = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NREQ-1:0][ADDR_W-1:0]      req_address,
  input  logic [NREQ-1:0]                  req_read,
  input  logic [NREQ-1:0]                  req_write,
  input  logic [NREQ-1:0][BE_W-1:0]        req_byteenable,
  input  logic [NREQ-1:0][DATA_W-1:0]      req_writedata,
  output logic [NREQ-1:0]                  req_waitrequest,
  output logic [DATA_W-1:0]                req_readdata,
  output logic [NREQ-1:0]                  req_readdatavalid,
  output logic [ADDR_W-1:0]                master_address,
  output logic                             master_read,
  output logic                             master_write,
  output logic [BE_W-1:0]                  master_byteenable,
  output logic [DATA_W-1:0]                master_writedata,
  input  logic [DATA_W-1:0]                master_readdata,
  input  logic                             master_readdatavalid,
  input  logic                             master_waitrequest,
  output logic                             rd_underflow,
  output logic [$clog2(MAX_PENDING):0]     pending_count
);

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  req_id_t    r_grant;
  req_id_t    w_grant_nxt;
  req_id_t    r_rr_ptr;
  req_id_t    w_rr_ptr_nxt;
  logic       r_underflow;

  logic [NREQ-1:0] w_elig;
  logic            w_req_active;
  logic            w_accept;
  logic            w_push;
  logic            w_pop;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  req_id_t         w_head_id;

  // Reads must wait for a free ID slot; writes never touch the FIFO.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_write[i] | (req_read[i] & ~w_fifo_full);
    end
  end

  // The granted requester drives the port; everything is zero while idle.
  always_comb begin
    master_address    = '0;
    master_read       = 1'b0;
    master_write      = 1'b0;
    master_byteenable = '0;
    master_writedata  = '0;
    if (r_state == ST_GRANT) begin
      master_address    = req_address[r_grant];
      master_read       = req_read[r_grant];
      master_write      = req_write[r_grant];
      master_byteenable = req_byteenable[r_grant];
      master_writedata  = req_writedata[r_grant];
    end
  end

  // Only the granted requester sees the port's stall released.
  always_comb begin
    req_waitrequest = '1;
    if ((r_state == ST_GRANT) && !master_waitrequest) req_waitrequest[r_grant] = 1'b0;
  end

  assign w_req_active = req_read[r_grant] | req_write[r_grant];
  assign w_accept     = (r_state == ST_GRANT) & (master_read | master_write) & ~master_waitrequest;
  assign w_push       = w_accept & master_read;
  assign w_pop        = master_readdatavalid & ~w_fifo_empty;

  // Read data is broadcast; the strobe goes to whoever owns the oldest outstanding read.
  always_comb begin
    req_readdatavalid = '0;
    if (w_pop) req_readdatavalid[w_head_id] = 1'b1;
  end

  assign req_readdata = master_readdata;
  assign rd_underflow = r_underflow;

  // Next grant/state: arbitrate in IDLE, leave GRANT on accept or when the request is withdrawn.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ST_IDLE: begin
        if (|w_elig) begin
          w_state_nxt = ST_GRANT;
          w_grant_nxt = rr_pick(w_elig, r_rr_ptr);
        end
      end
      ST_GRANT: begin
        if (w_accept) begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = next_id(r_grant);
        end else if (!w_req_active) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= REQ_VFETCH;
      r_rr_ptr <= REQ_VFETCH;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Sticky flag for a read return with nothing outstanding (includes returns for pre-reset reads).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_underflow <= 1'b0;
    end else if (master_readdatavalid && w_fifo_empty) begin
      r_underflow <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH(MAX_PENDING)
  ) u_id_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_push),
    .pop      (w_pop),
    .push_data(r_grant),
    .data     (w_head_id),
    .count    (pending_count),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, directed corner sequences, randomized traffic vs reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_port_arbiter;

  localparam int MAXP = 8;

  logic              clock;
  logic              reset;
  logic [2:0][25:0]  req_address;
  logic [2:0]        req_read;
  logic [2:0]        req_write;
  logic [2:0][3:0]   req_byteenable;
  logic [2:0][31:0]  req_writedata;
  logic [2:0]        req_waitrequest;
  logic [31:0]       req_readdata;
  logic [2:0]        req_readdatavalid;
  logic [25:0]       master_address;
  logic              master_read;
  logic              master_write;
  logic [3:0]        master_byteenable;
  logic [31:0]       master_writedata;
  logic [31:0]       master_readdata;
  logic              master_readdatavalid;
  logic              master_waitrequest;
  logic              rd_underflow;
  logic [3:0]        pending_count;

  mem_port_arbiter #(.MAX_PENDING(MAXP), .NREQ(3)) dut (
    .clock               (clock),
    .reset               (reset),
    .req_address         (req_address),
    .req_read            (req_read),
    .req_write           (req_write),
    .req_byteenable      (req_byteenable),
    .req_writedata       (req_writedata),
    .req_waitrequest     (req_waitrequest),
    .req_readdata        (req_readdata),
    .req_readdatavalid   (req_readdatavalid),
    .master_address      (master_address),
    .master_read         (master_read),
    .master_write        (master_write),
    .master_byteenable   (master_byteenable),
    .master_writedata    (master_writedata),
    .master_readdata     (master_readdata),
    .master_readdatavalid(master_readdatavalid),
    .master_waitrequest  (master_waitrequest),
    .rd_underflow        (rd_underflow),
    .pending_count       (pending_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: who owns the port (-1 = nobody), next preferred requester, outstanding read owners.
  int m_gnt;
  int m_rr;
  int m_q[$];
  bit m_uf;
  bit m_acc;
  int m_acc_id;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gnt = -1; m_rr = 0; m_q.delete(); m_uf = 0; m_acc = 0; m_acc_id = 0;
  endtask

  task automatic check_model();
    logic        e_rd, e_wr;
    logic [25:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [2:0]  e_wait, e_rdv;
    e_rd = 0; e_wr = 0; e_addr = '0; e_be = '0; e_wd = '0;
    e_wait = 3'b111; e_rdv = 3'b000;
    if (m_gnt >= 0) begin
      e_rd = req_read[m_gnt]; e_wr = req_write[m_gnt];
      e_addr = req_address[m_gnt]; e_be = req_byteenable[m_gnt]; e_wd = req_writedata[m_gnt];
      if (!master_waitrequest) e_wait[m_gnt] = 1'b0;
    end
    if (master_readdatavalid && m_q.size() > 0) e_rdv[m_q[0]] = 1'b1;
    chk("m_read", 64'(master_read), 64'(e_rd));
    chk("m_write", 64'(master_write), 64'(e_wr));
    chk("m_addr", 64'(master_address), 64'(e_addr));
    chk("m_be", 64'(master_byteenable), 64'(e_be));
    chk("m_wdata", 64'(master_writedata), 64'(e_wd));
    chk("waitreq", 64'(req_waitrequest), 64'(e_wait));
    chk("rdvalid", 64'(req_readdatavalid), 64'(e_rdv));
    if (e_rdv != 3'b000) chk("rdata", 64'(req_readdata), 64'(master_readdata));
    chk("pending", 64'(pending_count), 64'(m_q.size()));
    chk("underflow", 64'(rd_underflow), 64'(m_uf));
  endtask

  // Advance the model across one rising edge using the inputs that were applied to it.
  task automatic model_update();
    int sz, pick;
    bit act;
    if (!reset) begin
      model_reset();
      return;
    end
    sz = m_q.size();
    act = 0; m_acc = 0;
    if (m_gnt >= 0) begin
      act = req_read[m_gnt] | req_write[m_gnt];
      m_acc = act && !master_waitrequest;
      m_acc_id = m_gnt;
    end
    if (master_readdatavalid) begin
      if (sz > 0) void'(m_q.pop_front());
      else m_uf = 1;
    end
    if (m_acc && req_read[m_gnt]) m_q.push_back(m_gnt);
    if (m_gnt >= 0) begin
      if (m_acc) begin
        m_rr = (m_gnt + 1) % 3;
        m_gnt = -1;
      end else if (!act) begin
        m_gnt = -1;
      end
    end else begin
      pick = -1;
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_rr + k) % 3;
        if (pick < 0 && (req_write[i] || (req_read[i] && sz < MAXP))) pick = i;
      end
      m_gnt = pick;
    end
  endtask

  task automatic finish_cycle();
    check_model();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic step();
    @(negedge clock);
    finish_cycle();
  endtask

  typedef struct {
    logic [2:0] wr;
    logic       mw;
    logic [2:0] e_wait;
    logic       e_mwr;
    int         e_gnt;
  } vec_t;

  vec_t        tbl[20];
  logic [25:0] a_tab[3];
  logic [3:0]  be_tab[3];
  logic [31:0] wd_tab[3];
  bit          h_act[3];
  bit          h_rd[3];
  int          nacc;

  initial begin
    a_tab[0] = 26'h0000100; a_tab[1] = 26'h2AAAAAA; a_tab[2] = 26'h3FFFFFF;
    be_tab[0] = 4'hF; be_tab[1] = 4'h3; be_tab[2] = 4'hF;
    wd_tab[0] = 32'h0000_00A0; wd_tab[1] = 32'h1111_00A1; wd_tab[2] = 32'hCAFE_F00D;

    // Continuous writes from all three, then a write from 2 stalled five cycles.
    for (int c = 0; c < 12; c++) begin
      tbl[c].wr = 3'b111; tbl[c].mw = 1'b0;
      if (c % 2 == 0) begin
        tbl[c].e_wait = 3'b111; tbl[c].e_mwr = 1'b0; tbl[c].e_gnt = -1;
      end else begin
        tbl[c].e_gnt = (c / 2) % 3; tbl[c].e_mwr = 1'b1;
        tbl[c].e_wait = 3'b111; tbl[c].e_wait[(c / 2) % 3] = 1'b0;
      end
    end
    tbl[12] = '{3'b100, 1'b1, 3'b111, 1'b0, -1};
    for (int c = 13; c < 18; c++) tbl[c] = '{3'b100, 1'b1, 3'b111, 1'b1, 2};
    tbl[18] = '{3'b100, 1'b0, 3'b011, 1'b1, 2};
    tbl[19] = '{3'b000, 1'b0, 3'b111, 1'b0, -1};

    reset = 1'b0;
    req_read = '0; req_write = '0;
    for (int i = 0; i < 3; i++) begin
      req_address[i] = a_tab[i]; req_byteenable[i] = be_tab[i]; req_writedata[i] = wd_tab[i];
    end
    master_readdata = '0; master_readdatavalid = 1'b0; master_waitrequest = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_waitreq", 64'(req_waitrequest), 64'h7);
    chk("rst_mread", 64'(master_read), 64'h0);
    chk("rst_pending", 64'(pending_count), 64'h0);
    chk("rst_uflow", 64'(rd_underflow), 64'h0);
    reset = 1'b1;

    // Table-driven arbitration and stall vectors.
    for (int c = 0; c < 20; c++) begin
      req_write = tbl[c].wr; master_waitrequest = tbl[c].mw;
      @(negedge clock);
      chk("tbl_waitreq", 64'(req_waitrequest), 64'(tbl[c].e_wait));
      chk("tbl_mwrite", 64'(master_write), 64'(tbl[c].e_mwr));
      chk("tbl_maddr", 64'(master_address), (tbl[c].e_gnt < 0) ? 64'h0 : 64'(a_tab[tbl[c].e_gnt]));
      chk("tbl_mbe", 64'(master_byteenable), (tbl[c].e_gnt < 0) ? 64'h0 : 64'(be_tab[tbl[c].e_gnt]));
      finish_cycle();
    end

    // Single read from requester 0, returned three cycles after acceptance.
    req_read = 3'b001;
    step();
    @(negedge clock);
    chk("rd_accept_wait", 64'(req_waitrequest), 64'h6);
    chk("rd_accept_addr", 64'(master_address), 64'h100);
    finish_cycle();
    req_read = 3'b000;
    step(); step();
    master_readdatavalid = 1'b1; master_readdata = 32'hDEADBEEF;
    @(negedge clock);
    chk("rd_ret_pend_pre", 64'(pending_count), 64'h1);
    chk("rd_ret_strobe", 64'(req_readdatavalid), 64'h1);
    chk("rd_ret_data", 64'(req_readdata), 64'hDEADBEEF);
    finish_cycle();
    master_readdatavalid = 1'b0;
    @(negedge clock);
    chk("rd_ret_pend_post", 64'(pending_count), 64'h0);
    finish_cycle();

    // Withdrawn request leaves the round-robin pointer where it was.
    req_write = 3'b010;
    step(); step();
    req_write = 3'b001; master_waitrequest = 1'b1;
    step(); step();
    req_write = 3'b000;
    step();
    req_write = 3'b011; master_waitrequest = 1'b0;
    step();
    @(negedge clock);
    chk("drop_keeps_rr", 64'(req_waitrequest), 64'h6);
    finish_cycle();
    req_write = 3'b000;
    step();

    // Fill all read slots from requester 1, then show writes still flow and one return reopens reads.
    req_read = 3'b010; nacc = 0;
    for (int k = 0; k < 40 && nacc < MAXP; k++) begin
      step();
      if (m_acc) nacc++;
    end
    chk("full_reached", 64'(nacc), 64'(MAXP));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("full_stall_wait", 64'(req_waitrequest), 64'h7);
      chk("full_pending", 64'(pending_count), 64'(MAXP));
      finish_cycle();
    end
    req_write = 3'b100;
    step();
    @(negedge clock);
    chk("full_write_grant", 64'(req_waitrequest), 64'h3);
    finish_cycle();
    req_write = 3'b000;
    master_readdatavalid = 1'b1; master_readdata = 32'h0000_0001;
    step();
    master_readdatavalid = 1'b0;
    step();
    @(negedge clock);
    chk("ninth_accept", 64'(req_waitrequest), 64'h5);
    chk("ninth_mread", 64'(master_read), 64'h1);
    finish_cycle();
    req_read = 3'b000;
    master_readdatavalid = 1'b1;
    for (int k = 0; k < MAXP; k++) begin
      master_readdata = 32'h100 + k;
      @(negedge clock);
      chk("drain_strobe", 64'(req_readdatavalid), 64'h2);
      finish_cycle();
    end
    master_readdatavalid = 1'b0;
    @(negedge clock);
    chk("drain_pending", 64'(pending_count), 64'h0);
    finish_cycle();

    // Reads 0,1,0 with the third push landing on the first return.
    req_read = 3'b001; step(); step();
    req_read = 3'b010; step(); step();
    req_read = 3'b001; step();
    master_readdatavalid = 1'b1; master_readdata = 32'h1111_1111;
    @(negedge clock);
    chk("ilv_strobe0", 64'(req_readdatavalid), 64'h1);
    chk("ilv_accept", 64'(req_waitrequest), 64'h6);
    finish_cycle();
    req_read = 3'b000; master_readdata = 32'h2222_2222;
    @(negedge clock);
    chk("ilv_pp_count", 64'(pending_count), 64'h2);
    chk("ilv_strobe1", 64'(req_readdatavalid), 64'h2);
    finish_cycle();
    master_readdata = 32'h3333_3333;
    @(negedge clock);
    chk("ilv_strobe2", 64'(req_readdatavalid), 64'h1);
    chk("ilv_data2", 64'(req_readdata), 64'h3333_3333);
    finish_cycle();
    master_readdatavalid = 1'b0;
    step();

    // Reset in the middle of a stalled grant with a read outstanding.
    req_read = 3'b010; step(); step();
    req_read = 3'b001; master_waitrequest = 1'b1; step();
    @(negedge clock);
    chk("pre_rst_mread", 64'(master_read), 64'h1);
    check_model();
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_mread", 64'(master_read), 64'h0);
    chk("mid_rst_maddr", 64'(master_address), 64'h0);
    chk("mid_rst_mbe", 64'(master_byteenable), 64'h0);
    chk("mid_rst_waitreq", 64'(req_waitrequest), 64'h7);
    chk("mid_rst_pending", 64'(pending_count), 64'h0);
    chk("mid_rst_rdv", 64'(req_readdatavalid), 64'h0);
    @(posedge clock);
    model_update();
    #1;
    reset = 1'b1; req_read = 3'b000; master_waitrequest = 1'b0;
    master_readdatavalid = 1'b1; master_readdata = 32'h5555_AAAA;
    @(negedge clock);
    chk("stale_ret_rdv", 64'(req_readdatavalid), 64'h0);
    finish_cycle();
    master_readdatavalid = 1'b0;
    @(negedge clock);
    chk("underflow_set", 64'(rd_underflow), 64'h1);
    finish_cycle();
    step();
    chk("underflow_sticky", 64'(rd_underflow), 64'h1);
    reset = 1'b0;
    @(posedge clock);
    model_update();
    #1;
    chk("underflow_clr", 64'(rd_underflow), 64'h0);
    reset = 1'b1;

    // Randomized traffic: requests held until accepted, occasional withdrawal, random stalls and returns.
    for (int i = 0; i < 3; i++) begin h_act[i] = 0; h_rd[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (h_act[i] && m_acc && m_acc_id == i) begin
          h_act[i] = 0;
        end else if (h_act[i] && $urandom_range(39) == 0) begin
          h_act[i] = 0;
        end else if (!h_act[i] && $urandom_range(2) == 0) begin
          h_act[i] = 1;
          h_rd[i] = 1'($urandom_range(1));
          req_address[i] = 26'($urandom);
          req_byteenable[i] = 4'($urandom);
          req_writedata[i] = $urandom;
        end
        req_read[i] = h_act[i] & h_rd[i];
        req_write[i] = h_act[i] & ~h_rd[i];
      end
      master_waitrequest = ($urandom_range(3) == 0);
      master_readdatavalid = (m_q.size() > 0) && ($urandom_range(2) == 0);
      master_readdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_PENDING, default 8, max outstanding reads (power of 2, 2..16).
REQ-002 SHALL have parameter NREQ, default 3, number of requester ports (fixed at 3 in this revision).
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous active-low reset
- req_address  in  [2:0][25:0]  per-requester word address
- req_read  in  [2:0]  per-requester read request
- req_write  in  [2:0]  per-requester write request
- req_byteenable  in  [2:0][3:0]  per-requester byte enables
- req_writedata  in  [2:0][31:0]  per-requester write data
- req_waitrequest  out  [2:0]  per-requester stall
- req_readdata  out  32  read data, shared by all requesters
- req_readdatavalid  out  [2:0]  per-requester read-return strobe
- master_address  out  26  to SDRAM port
- master_read  out  1
- master_write  out  1
- master_byteenable  out  4
- master_writedata  out  32
- master_readdata  in  32
- master_readdatavalid  in  1
- master_waitrequest  in  1
- rd_underflow  out  1  sticky: readdatavalid arrived with no read pending
- pending_count  out  $clog2(MAX_PENDING)+1  outstanding reads

Function
REQ-005 SHALL implement FSM IDLE/GRANT; requester 0 = vertex fetch, 1 = depth fetch, 2 = z-test write.
REQ-006 IDLE: if any req_read|req_write is eligible, SHALL register grant to the first eligible index at or after rr_ptr (mod 3) and enter GRANT next cycle.
REQ-007 A read request SHALL be ineligible while pending_count == MAX_PENDING; writes stay eligible.
REQ-008 GRANT: master_* SHALL mirror the granted requester's signals combinationally; other requesters see no effect.
REQ-009 req_waitrequest[i] SHALL be 0 only when in GRANT, i granted, and master_waitrequest == 0; otherwise 1.
REQ-010 Acceptance = GRANT & (master_read|master_write) & !master_waitrequest. On acceptance, SHALL return to IDLE and set rr_ptr = grant+1 mod 3.
REQ-011 If the granted requester drops both read and write in GRANT, SHALL return to IDLE without a transfer and leave rr_ptr unchanged.
REQ-012 In IDLE, master_read, master_write, master_byteenable, master_address, and master_writedata SHALL be 0.
REQ-013 Minimum request-to-accept latency: 1 cycle. Peak throughput: one transfer per 2 cycles.
REQ-014 On an accepted read, SHALL push the granted ID into an in-order ID FIFO of depth MAX_PENDING.
REQ-015 On master_readdatavalid with FIFO non-empty:
- SHALL assert req_readdatavalid[head ID] the same cycle (combinational)
- req_readdata SHALL equal master_readdata
- SHALL pop the FIFO head
REQ-016 Simultaneous push and pop SHALL leave pending_count unchanged. FIFO pointers SHALL wrap modulo MAX_PENDING.
REQ-017 master_readdatavalid with FIFO empty SHALL:
- assert no req_readdatavalid
- set rd_underflow to 1 until reset

Reset
REQ-018 Asserting reset SHALL, at any time including mid-transfer or with reads pending:
- force state IDLE, rr_ptr 0, FIFO empty, pending_count 0, rd_underflow 0
- drive all master_* outputs 0, req_waitrequest 3'b111, req_readdatavalid 0
REQ-019 Read returns for reads issued before reset SHALL be treated as underflow after reset.

Structure
REQ-020 Package rast_mem_pkg SHALL hold:
- ADDR_W=26, DATA_W=32, BE_W=4
- typedef req_id_t (2 bits)
- requester ID constants REQ_VFETCH=0, REQ_ZFETCH=1, REQ_ZWRITE=2
- FSM state enum
REQ-021 The ID FIFO SHALL be a sub-module arb_id_fifo (push, pop, data, count, full, empty).

Verification
REQ-022 Bench SHALL cover these scenarios:
- Single read, ID 0, address 0x100, waitrequest 0: accepted on cycle 1; readdatavalid 3 cycles later with 0xDEADBEEF -> req_readdatavalid=3'b001, req_readdata=0xDEADBEEF, pending_count 1 -> 0.
- All three requesters request continuously from reset: grant order 0,1,2,0,1,2; each accepted in alternate cycles.
- master_waitrequest held 1 for 5 cycles during a grant to 2 (write, 0x3FFFFFF, be 4'hF): grant held, master_* stable, req_waitrequest=3'b111, accept on release.
- Eight reads from ID 1 with no returns: ninth read stalls, pending_count=8; a write from 2 is still granted; one return -> ninth read accepted.
- Returns interleaved for IDs 0,1,0 with a push on the same cycle as a pop: strobes routed in issue order; count stable on that cycle.
- Spurious master_readdatavalid when empty -> rd_underflow=1; reset mid-GRANT -> all outputs at reset values within the same cycle.
